// File: rtl/ysyx_22041207_pkg.sv
// Shared core package: ALU opcodes, LSU FSM encoding and access-size constants.
package ysyx_22041207_pkg;

    // ALU operation select driven by the decoder
    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluXor,
        AluSll,
        AluSrl,
        AluSra,
        AluSlt,
        AluSltu
    } alu_op_e;

    // Load/store unit controller states
    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } lsu_state_e;

    // Access sizes in bytes
    localparam logic [3:0] SizeByte   = 4'd1;
    localparam logic [3:0] SizeHalf   = 4'd2;
    localparam logic [3:0] SizeWord   = 4'd4;
    localparam logic [3:0] SizeDouble = 4'd8;

    // Number of bytes enabled in a store mask
    function automatic logic [3:0] popcount8(input logic [7:0] mask);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(mask[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ysyx_22041207_load_ext.sv
// Load data alignment: shifts the addressed bytes to bit 0, truncates to the
// access size and sign- or zero-extends to XLEN.
module ysyx_22041207_load_ext
    import ysyx_22041207_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int OFFW = 3
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [OFFW-1:0] offset,
    input  logic [3:0]      size,
    input  logic            sext,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    // Truncate to the access size and extend
    always_comb begin
        data = shifted;
        case (size)
            SizeByte: data = sext ? {{(XLEN-8){shifted[7]}}, shifted[7:0]}
                                  : {{(XLEN-8){1'b0}}, shifted[7:0]};
            SizeHalf: data = sext ? {{(XLEN-16){shifted[15]}}, shifted[15:0]}
                                  : {{(XLEN-16){1'b0}}, shifted[15:0]};
            SizeWord: data = sext ? {{(XLEN-32){shifted[31]}}, shifted[31:0]}
                                  : {{(XLEN-32){1'b0}}, shifted[31:0]};
            default:  data = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22041207_lsu.sv
// Load/store unit: accepts one access at a time from execute, drives an aligned
// memory bus request, and returns a one-cycle completion pulse to writeback.
// No-op and boundary-crossing accesses complete without touching the bus.
module ysyx_22041207_lsu
    import ysyx_22041207_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int BUS_BYTES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_ren,
    input  logic [7:0]      req_wmask,
    input  logic [3:0]      req_rnum,
    input  logic            req_sext,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [7:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_misalign
);

    localparam int OffW = $clog2(BUS_BYTES);

    lsu_state_e      state_q;
    logic            is_load_q;
    logic [OffW-1:0] offset_q;
    logic [3:0]      size_q;
    logic            sext_q;

    logic [OffW-1:0] off;
    logic            is_noop;
    logic [3:0]      size;
    logic [4:0]      span;
    logic            misalign;
    logic [XLEN-1:0] ld_data;

    // Request decode: loads win over a simultaneous store mask
    always_comb begin
        off      = req_addr[OffW-1:0];
        is_noop  = !req_ren && (req_wmask == 8'd0);
        size     = req_ren ? req_rnum : popcount8(req_wmask);
        span     = 5'(off) + 5'(size);
        misalign = !is_noop && (span > 5'(BUS_BYTES));
    end

    assign req_ready = (state_q == StIdle);

    ysyx_22041207_load_ext #(
        .XLEN (XLEN),
        .OFFW (OffW)
    ) u_load_ext (
        .rdata  (mem_rdata),
        .offset (offset_q),
        .size   (size_q),
        .sext   (sext_q),
        .data   (ld_data)
    );

    // Controller FSM with registered bus and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            is_load_q    <= 1'b0;
            offset_q     <= '0;
            size_q       <= 4'd0;
            sext_q       <= 1'b0;
            mem_valid    <= 1'b0;
            mem_addr     <= '0;
            mem_wen      <= 1'b0;
            mem_wstrb    <= 8'd0;
            mem_wdata    <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_misalign <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        is_load_q <= req_ren;
                        offset_q  <= off;
                        size_q    <= size;
                        sext_q    <= req_sext;
                        if (is_noop || misalign) begin
                            state_q      <= StResp;
                            rsp_valid    <= 1'b1;
                            rsp_rdata    <= '0;
                            rsp_misalign <= misalign;
                        end else begin
                            state_q   <= StReq;
                            mem_valid <= 1'b1;
                            mem_addr  <= {req_addr[XLEN-1:OffW], {OffW{1'b0}}};
                            mem_wen   <= !req_ren;
                            mem_wstrb <= req_ren ? 8'd0 : (req_wmask << off);
                            mem_wdata <= req_ren ? '0 : (req_wdata << {off, 3'b000});
                        end
                    end
                end
                StReq: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_wen   <= 1'b0;
                        mem_wstrb <= 8'd0;
                        // Response may coincide with acceptance
                        if (mem_rvalid) begin
                            state_q   <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= is_load_q ? ld_data : '0;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (mem_rvalid) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= is_load_q ? ld_data : '0;
                    end
                end
                StResp: begin
                    state_q      <= StIdle;
                    rsp_valid    <= 1'b0;
                    rsp_rdata    <= '0;
                    rsp_misalign <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/ysyx_22041207_lsu.md
YSYX_22041207_LSU -- requirements
Module: ysyx_22041207_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 64, data and address width.
REQ-002 SHALL have parameter BUS_BYTES, default 8, memory bus width in bytes.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  access request from execute stage.
REQ-006 req_ready  output  1  LSU can accept a request.
REQ-007 req_ren  input  1  load request (memoryReadWen).
REQ-008 req_wmask  input  8  store byte mask, LSB-aligned: 01/03/0F/FF (memoryWriteMask).
REQ-009 req_rnum  input  4  load size in bytes: 1/2/4/8 (readNum).
REQ-010 req_sext  input  1  sign-extend load result.
REQ-011 req_addr  input  XLEN  effective address (ALU rs1+imm).
REQ-012 req_wdata  input  XLEN  store data (rs2), LSB-aligned.
REQ-013 mem_valid  output  1  bus request valid.
REQ-014 mem_ready  input  1  bus accepts request.
REQ-015 mem_addr  output  XLEN  bus address, req_addr with bits [2:0] cleared.
REQ-016 mem_wen  output  1  bus write.
REQ-017 mem_wstrb  output  8  byte strobe, req_wmask shifted left by addr[2:0].
REQ-018 mem_wdata  output  XLEN  req_wdata shifted left by 8*addr[2:0].
REQ-019 mem_rvalid  input  1  bus response valid (read data or write ack).
REQ-020 mem_rdata  input  XLEN  bus read data.
REQ-021 rsp_valid  output  1  one-cycle completion pulse to writeback.
REQ-022 rsp_rdata  output  XLEN  extracted, extended load data; 0 for stores.
REQ-023 rsp_misalign  output  1  valid with rsp_valid; access crossed 8-byte boundary.

Function
REQ-024 FSM states SHALL be IDLE, REQ, WAIT, RESP.
REQ-025 req_ready SHALL be 1 only in IDLE; request accepted when req_valid && req_ready.
REQ-026 Accepted request with neither req_ren nor nonzero req_wmask SHALL go IDLE->RESP without bus activity, rsp_rdata=0.
REQ-027 Accepted request with req_ren and req_wmask both nonzero SHALL be treated as a load.
REQ-028 Access size = req_rnum (load) or popcount(req_wmask) (store); misaligned when addr[2:0]+size>8.
REQ-029 Misaligned request SHALL go IDLE->RESP with rsp_misalign=1, rsp_rdata=0, no mem_valid.
REQ-030 Aligned request SHALL register all request fields and go IDLE->REQ.
REQ-031 In REQ, mem_valid=1 with stable address/strobe/data until mem_ready; then ->WAIT.
REQ-032 mem_rvalid in the same cycle as mem_ready SHALL go REQ->RESP directly.
REQ-033 In WAIT, mem_rvalid SHALL capture mem_rdata and go ->RESP; mem_rvalid outside REQ/WAIT SHALL be ignored.
REQ-034 Load data SHALL be mem_rdata >> 8*addr[2:0], truncated to size, sign- or zero-extended per req_sext.
REQ-035 In RESP, rsp_valid=1 for exactly one cycle, then ->IDLE; minimum latency request-to-rsp_valid is 2 cycles on bus path, 1 cycle on no-op/misaligned path.
REQ-036 mem_wen=0 and mem_wstrb=0 for loads; mem_wstrb=0 whenever mem_valid=0.
REQ-037 Only one outstanding access; no new request accepted before RESP completes.

Reset
REQ-038 rst_n low SHALL immediately force state IDLE, mem_valid=0, rsp_valid=0, rsp_misalign=0, rsp_rdata=0, mem_wstrb=0, req_ready=1 after release.
REQ-039 Reset mid-transaction SHALL abandon the access; late mem_rvalid after reset SHALL be ignored.

Structure
REQ-040 FSM state encoding and size constants (1/2/4/8) SHALL live in the shared package alongside the ALU opcode defines.
REQ-041 Load alignment/extension SHALL be a combinational sub-module ysyx_22041207_load_ext.

Verification
REQ-042 ld addr 0x80000008, mem_rdata 0x1122334455667788 -> mem_addr 0x80000008, rsp_rdata 0x1122334455667788.
REQ-043 lb sext addr 0x80000003, mem_rdata 0x00000000_80000000_ shifted byte 0x80 -> rsp_rdata 0xFFFFFFFFFFFFFF80; lbu same -> 0x80.
REQ-044 sh addr 0x80000006, wdata 0xBEEF -> mem_wstrb 0xC0, mem_wdata 0xBEEF000000000000, mem_wen 1.
REQ-045 sw addr 0x80000006 -> rsp_misalign 1, mem_valid never asserted.
REQ-046 mem_ready held low 5 cycles -> mem_valid and fields stable, req_ready 0 throughout.
REQ-047 rst_n asserted in WAIT, then mem_rvalid -> no rsp_valid, state IDLE.
